// File: rtl/huffman_pkg.sv
// Shared widths and state encoding for the Huffman coder and bit packer.
package huffman_pkg;

    localparam int unsigned MAX_CODE_LEN = 10;
    localparam int unsigned LEN_W        = 4;
    localparam int unsigned BUF_W        = 24;

    typedef enum logic [1:0] {
        PK_RUN   = 2'd0,
        PK_DRAIN = 2'd1,
        PK_LAST  = 2'd2,
        PK_DONE  = 2'd3
    } packer_state_t;

endpackage

// File: rtl/huffman_bit_packer.sv
// Packs right-aligned variable-length codes into an MSB-first byte stream,
// with ready/valid on both sides and a flush that pads the final byte.
module huffman_bit_packer #(
    parameter int unsigned MAX_LEN = huffman_pkg::MAX_CODE_LEN,
    parameter int unsigned BUF_W   = huffman_pkg::BUF_W
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [MAX_LEN-1:0]            code_in,
    input  logic [huffman_pkg::LEN_W-1:0] len_in,
    input  logic                          code_valid,
    output logic                          code_ready,
    input  logic                          flush,
    output logic [7:0]                    byte_out,
    output logic                          byte_valid,
    input  logic                          byte_ready,
    output logic                          byte_last,
    output logic [2:0]                    pad_bits,
    output logic                          flush_done,
    output logic                          len_err
);

    import huffman_pkg::*;

    localparam int unsigned CNT_W = $clog2(BUF_W + 1);
    typedef logic [CNT_W-1:0] cnt_t;

    localparam cnt_t             FULL_CNT  = cnt_t'(BUF_W);
    localparam cnt_t             READY_LIM = cnt_t'(BUF_W - MAX_LEN);
    localparam cnt_t             BYTE_CNT  = cnt_t'(8);
    localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);

    packer_state_t    state, state_nxt;
    logic [BUF_W-1:0] bit_buf, buf_nxt;
    cnt_t             count, count_nxt;
    logic             len_err_q;

    logic             accept;
    logic             emit_full;
    logic             emit_last;
    logic             len_legal;
    logic             len_bad;
    logic [BUF_W-1:0] shifted;
    logic [BUF_W-1:0] ins_bits;
    logic [MAX_LEN-1:0] len_mask;
    cnt_t             base_cnt;
    cnt_t             ins_shamt;
    logic [7:0]       last_mask;

    assign accept    = code_valid && code_ready;
    assign emit_full = ((state == PK_RUN) || (state == PK_DRAIN)) &&
                       (count >= BYTE_CNT) && byte_ready;
    assign emit_last = (state == PK_LAST) && byte_ready;
    assign len_legal = (len_in != '0) && (len_in <= MAX_LEN_L);
    assign len_bad   = (len_in > MAX_LEN_L);
    assign len_err   = len_err_q;

    // Next accumulator contents: shift out an emitted byte first, then append
    // the new code directly below the remaining valid bits.
    always_comb begin
        shifted   = emit_full ? (bit_buf << 8) : bit_buf;
        base_cnt  = emit_full ? (count - BYTE_CNT) : count;
        len_mask  = ~({MAX_LEN{1'b1}} << len_in);
        ins_shamt = FULL_CNT - base_cnt - cnt_t'(len_in);
        ins_bits  = BUF_W'(code_in & len_mask) << ins_shamt;
        buf_nxt   = shifted;
        count_nxt = base_cnt;
        if (accept && len_legal) begin
            buf_nxt   = shifted | ins_bits;
            count_nxt = base_cnt + cnt_t'(len_in);
        end
        if (emit_last) begin
            buf_nxt   = '0;
            count_nxt = '0;
        end
    end

    // Accumulator, bit count and sticky length-error registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_buf   <= '0;
            count     <= '0;
            len_err_q <= 1'b0;
        end else begin
            bit_buf <= buf_nxt;
            count   <= count_nxt;
            if (accept && len_bad) begin
                len_err_q <= 1'b1;
            end
        end
    end

    // Packer state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= PK_RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and output decode from registered state and count only;
    // code_ready is additionally held low while reset is asserted.
    always_comb begin
        state_nxt  = state;
        code_ready = 1'b0;
        byte_valid = 1'b0;
        byte_last  = 1'b0;
        pad_bits   = '0;
        flush_done = 1'b0;
        last_mask  = ~(8'hFF >> count);
        byte_out   = bit_buf[BUF_W-1 -: 8];

        unique case (state)
            PK_RUN: begin
                code_ready = rst_n && (count <= READY_LIM);
                byte_valid = (count >= BYTE_CNT);
                if (flush) begin
                    state_nxt = PK_DRAIN;
                end
            end
            PK_DRAIN: begin
                byte_valid = (count >= BYTE_CNT);
                if (count < BYTE_CNT) begin
                    state_nxt = (count == '0) ? PK_DONE : PK_LAST;
                end
            end
            PK_LAST: begin
                byte_valid = 1'b1;
                byte_last  = 1'b1;
                byte_out   = bit_buf[BUF_W-1 -: 8] & last_mask;
                pad_bits   = 3'(BYTE_CNT - count);
                if (byte_ready) begin
                    state_nxt = PK_DONE;
                end
            end
            PK_DONE: begin
                flush_done = 1'b1;
                state_nxt  = PK_RUN;
            end
            default: begin
                state_nxt = PK_RUN;
            end
        endcase
    end

endmodule

// File: tb/tb_huffman_bit_packer.sv
// Directed bench for huffman_bit_packer with hand-computed expected bytes.
module tb_huffman_bit_packer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [9:0] code_in = '0;
    logic [3:0] len_in = '0;
    logic       code_valid = 1'b0;
    logic       code_ready;
    logic       flush = 1'b0;
    logic [7:0] byte_out;
    logic       byte_valid;
    logic       byte_ready = 1'b0;
    logic       byte_last;
    logic [2:0] pad_bits;
    logic       flush_done;
    logic       len_err;

    int checks = 0;
    int errors = 0;

    huffman_bit_packer #(
        .MAX_LEN(10),
        .BUF_W  (24)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .code_in   (code_in),
        .len_in    (len_in),
        .code_valid(code_valid),
        .code_ready(code_ready),
        .flush     (flush),
        .byte_out  (byte_out),
        .byte_valid(byte_valid),
        .byte_ready(byte_ready),
        .byte_last (byte_last),
        .pad_bits  (pad_bits),
        .flush_done(flush_done),
        .len_err   (len_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset
        #2 rst_n = 1'b0;
        #10;
        chk("rst_byte_valid", 32'(byte_valid), 0);
        chk("rst_byte_out",   32'(byte_out),   0);
        chk("rst_byte_last",  32'(byte_last),  0);
        chk("rst_pad_bits",   32'(pad_bits),   0);
        chk("rst_flush_done", 32'(flush_done), 0);
        chk("rst_len_err",    32'(len_err),    0);
        chk("rst_code_ready", 32'(code_ready), 0);
        #10 rst_n = 1'b1;
        #1;
        chk("rel_code_ready", 32'(code_ready), 1);
        step();

        // Three 101 codes -> 0xB6, then flush of the single leftover bit
        byte_ready = 1'b1;
        code_valid = 1'b1; code_in = 10'h005; len_in = 4'd3;
        step(); step();
        chk("t1_cnt6_no_byte", 32'(byte_valid), 0);
        step();
        code_valid = 1'b0;
        chk("t1_byte_valid", 32'(byte_valid), 1);
        chk("t1_byte_b6",    32'(byte_out),   32'hB6);
        step();
        chk("t1_emitted",    32'(byte_valid), 0);
        chk("t1_ready",      32'(code_ready), 1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("t1_drain_ready", 32'(code_ready), 0);
        chk("t1_drain_bv",    32'(byte_valid), 0);
        step();
        chk("t1_last_bv",   32'(byte_valid), 1);
        chk("t1_last_flag", 32'(byte_last),  1);
        chk("t1_last_byte", 32'(byte_out),   32'h80);
        chk("t1_last_pad",  32'(pad_bits),   7);
        step();
        chk("t1_done",      32'(flush_done), 1);
        chk("t1_done_bv",   32'(byte_valid), 0);
        chk("t1_done_pad",  32'(pad_bits),   0);
        step();
        chk("t1_done_pulse", 32'(flush_done), 0);
        chk("t1_run_ready",  32'(code_ready), 1);

        // Back-pressure: two 10-bit codes fill to 20, then stall
        byte_ready = 1'b0;
        code_valid = 1'b1; code_in = 10'h3FF; len_in = 4'd10;
        step();
        chk("t2_bv_10",    32'(byte_valid), 1);
        chk("t2_byte_10",  32'(byte_out),   32'hFF);
        chk("t2_ready_10", 32'(code_ready), 1);
        step();
        chk("t2_ready_20", 32'(code_ready), 0);
        step();
        chk("t2_hold_byte", 32'(byte_out),   32'hFF);
        chk("t2_hold_bv",   32'(byte_valid), 1);
        code_valid = 1'b0;
        byte_ready = 1'b1;
        step();
        chk("t2_second_bv",   32'(byte_valid), 1);
        chk("t2_second_byte", 32'(byte_out),   32'hFF);
        step();
        chk("t2_cnt4_bv",    32'(byte_valid), 0);
        chk("t2_cnt4_ready", 32'(code_ready), 1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        step();
        chk("t2_last_byte", 32'(byte_out),  32'hF0);
        chk("t2_last_pad",  32'(pad_bits),  4);
        chk("t2_last_flag", 32'(byte_last), 1);
        step();
        chk("t2_done", 32'(flush_done), 1);
        step();

        // Zero-length and over-length codes
        code_valid = 1'b1; code_in = 10'h3FF; len_in = 4'd0;
        step();
        chk("t3_len0_bv",    32'(byte_valid), 0);
        chk("t3_len0_err",   32'(len_err),    0);
        len_in = 4'd12;
        step();
        code_valid = 1'b0;
        chk("t3_len12_err",  32'(len_err),    1);
        chk("t3_len12_bv",   32'(byte_valid), 0);
        byte_ready = 1'b0;
        code_valid = 1'b1; code_in = 10'h0A5; len_in = 4'd8;
        step();
        code_valid = 1'b0;
        chk("t3_clean_bv",   32'(byte_valid), 1);
        chk("t3_clean_byte", 32'(byte_out),   32'hA5);
        byte_ready = 1'b1;
        step();
        chk("t3_clean_gone", 32'(byte_valid), 0);

        // Flush with nothing buffered
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("t4_empty_drain_bv", 32'(byte_valid), 0);
        chk("t4_empty_drain_fd", 32'(flush_done), 0);
        step();
        chk("t4_empty_done",     32'(flush_done), 1);
        chk("t4_empty_no_last",  32'(byte_last),  0);
        chk("t4_empty_no_bv",    32'(byte_valid), 0);
        step();
        chk("t4_empty_pulse",    32'(flush_done), 0);

        // Code accepted in the flush cycle is part of the stream
        code_valid = 1'b1; code_in = 10'h2A5; len_in = 4'd10; flush = 1'b1;
        step();
        code_valid = 1'b0; flush = 1'b0;
        chk("t4_a9_bv",    32'(byte_valid), 1);
        chk("t4_a9_byte",  32'(byte_out),   32'hA9);
        chk("t4_a9_last",  32'(byte_last),  0);
        step();
        chk("t4_cnt2_bv",  32'(byte_valid), 0);
        step();
        chk("t4_last_flag", 32'(byte_last), 1);
        chk("t4_last_byte", 32'(byte_out),  32'h40);
        chk("t4_last_pad",  32'(pad_bits),  6);
        step();
        chk("t4_done",      32'(flush_done), 1);
        step();
        chk("t4_err_sticky", 32'(len_err), 1);

        // Asynchronous reset mid-stream with count 13
        byte_ready = 1'b0;
        code_valid = 1'b1; code_in = 10'h3FF; len_in = 4'd10;
        step();
        code_in = 10'h007; len_in = 4'd3;
        step();
        code_valid = 1'b0;
        chk("t5_pre_bv", 32'(byte_valid), 1);
        #3 rst_n = 1'b0;
        #1;
        chk("t5_async_bv",    32'(byte_valid), 0);
        chk("t5_async_byte",  32'(byte_out),   0);
        chk("t5_async_err",   32'(len_err),    0);
        chk("t5_async_ready", 32'(code_ready), 0);
        chk("t5_async_last",  32'(byte_last),  0);
        #3 rst_n = 1'b1;
        #1;
        chk("t5_rel_ready", 32'(code_ready), 1);
        chk("t5_rel_bv",    32'(byte_valid), 0);
        code_valid = 1'b1; code_in = 10'h0FF; len_in = 4'd8;
        step();
        code_valid = 1'b0;
        chk("t5_fresh_bv",   32'(byte_valid), 1);
        chk("t5_fresh_byte", 32'(byte_out),   32'hFF);
        byte_ready = 1'b1;
        step();
        chk("t5_no_stale", 32'(byte_valid), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/huffman_bit_packer.md
# huffman_bit_packer

Packs the variable-length Huffman codes from `huffman_coder` (code up to 10 bits, 4-bit length, valid strobe) into a contiguous MSB-first byte stream. It sits between the coder and the byte-wide output path and is the block that sequences the coded stream toward the pins or a FIFO. It provides ready/valid back-pressure on both sides and a flush sequence that emits a zero-padded final byte and reports the pad count.

## Interface
Parameters:
- `MAX_LEN`, 10: maximum legal code length in bits.
- `BUF_W`, 24: bit-accumulator width; must be ≥ `MAX_LEN` + 14.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `code_in` in 10: Huffman code, right-aligned; bit `len_in-1` is transmitted first.
- `len_in` in 4: code length, 0..15.
- `code_valid` in 1: code/length valid.
- `code_ready` out 1: packer can accept this cycle.
- `flush` in 1: request end-of-stream; sampled in RUN only.
- `byte_out` out 8: packed byte; bit 7 is the oldest bit.
- `byte_valid` out 1: `byte_out` valid.
- `byte_ready` in 1: consumer accepts the byte.
- `byte_last` out 1: qualifies `byte_out` as the final (padded) byte of a flush.
- `pad_bits` out 3: number of zero pad LSBs in the last byte; 0 unless `byte_last`.
- `flush_done` out 1: one-cycle pulse when the flush is complete.
- `len_err` out 1: sticky; set when an illegal length is seen.

## Operation
- Accumulator: `buf[BUF_W-1:0]`, left-aligned. `buf[BUF_W-1]` holds the oldest bit. `count` (5 bits, 0..24) holds the number of valid bits.
- Accept when `code_valid && code_ready`.
  - The low `len_in` bits of `code_in` are written to `buf[BUF_W-1-count -: len_in]`.
  - `count += len_in`.
- `len_in == 0`: accepted, no effect.
- `len_in > MAX_LEN`: accepted and dropped; `count` unchanged; `len_err` set until reset.
- `code_ready = (state == RUN) && (count <= BUF_W - MAX_LEN)`, i.e. `count <= 14`.
- `byte_out = buf[BUF_W-1 -: 8]`.
- Emit when `byte_valid && byte_ready`: `buf <<= 8`, `count -= 8`.
- Accept and emit in the same cycle:
  - Shift happens first, then the new bits are appended at `count-8`.
  - `count_next = count + len - 8`.
- State machine, encoded 2 bits:
  - RUN: normal operation. `byte_valid = (count >= 8)`.
    - `flush`=1 → DRAIN. A code accepted in that same cycle is included in the stream.
  - DRAIN: `code_ready=0`. Full bytes are emitted as in RUN.
    - When `count < 8` and no emit is pending: `count == 0` → DONE; else → LAST.
  - LAST: `byte_valid=1`, `byte_last=1`, `byte_out = buf` top bits with zeros below, `pad_bits = 8 - count`.
    - On `byte_ready` → DONE, and `count` clears to 0.
  - DONE: `flush_done=1` for exactly one cycle → RUN.
- `flush` outside RUN is ignored. `flush` held high re-triggers in the next RUN cycle.
- Reset state:
  - State RUN, `buf=0`, `count=0`.
  - `byte_valid=0`, `byte_last=0`, `pad_bits=0`, `flush_done=0`, `len_err=0`.
  - `code_ready=1` once `rst_n` is high.

## Timing
- All outputs are registered or decoded from registered state only. There is no combinational path from `code_valid`/`byte_ready` to any output.
- Latency: a code accepted at edge N that brings `count` to ≥ 8 gives `byte_valid=1` in the cycle after edge N.
- Throughput: one code accepted and one byte emitted per cycle, sustained.
- While `byte_valid && !byte_ready`, `byte_out`, `byte_last` and `pad_bits` stay stable.
- Flush, `count=c` (c < 8) with no full bytes left: DRAIN→LAST takes 1 cycle, then LAST waits for `byte_ready`, then DONE takes 1 cycle.
- Flush with `count=0`: DRAIN → DONE; `flush_done` asserts 2 cycles after `flush` is sampled.
- `rst_n` low mid-stream: all state clears immediately (asynchronous). A partially packed byte is discarded, with no output glitch to a valid byte.

## Structure
- Shared package `huffman_pkg` holds:
  - `MAX_CODE_LEN=10`, `LEN_W=4`, `BUF_W=24`.
  - The packer state enum {RUN, DRAIN, LAST, DONE}.
  - `huffman_coder` will also use it for its 10/4-bit widths.
- Single module, no sub-modules. The append/shift logic is one always block, and the FSM is a second.
- The top level instantiates it after `huffman_coder`, wiring `valid_out` → `code_valid`.

## Test plan
- Send three codes of `101`, len 3, with `byte_ready=1` → one byte `0xB6` (10110110), `count=1`. Then flush → `byte_out=0x80`, `byte_last=1`, `pad_bits=7`, then `flush_done` pulses.
- With `byte_ready=0`, send `0x3FF` len 10 repeatedly → two codes accepted (`count` 10 → 20), then `code_ready=0`. `byte_out=0xFF` is held stable. Release `byte_ready` → bytes `0xFF`,`0xFF`, then `code_ready=1` when `count=4`.
- Send len 0, then len 12 with `code_in=0x3FF` → `count` stays 0 and `byte_valid` stays 0; `len_err=1` until reset.
- Flush with `count=0` → no byte is emitted, `byte_last` never asserts, and `flush_done` pulses once. Code `0x2A5` len 10 sent in the same cycle as the flush → `0xA9` emitted, then last byte `0x40` with `pad_bits=6`.
- Assert `rst_n=0` with `count=13` and `byte_valid=1` → all outputs are 0 asynchronously. After release, the first code (`0xFF` len 8) yields `0xFF` with no stale bits.
